// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control unit: instruction FSM with memory handshake and a
// watchdog that traps to a sticky ERROR state when memory stops answering.
module mips_mc_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcen,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       alusrca,
    output logic       iord,
    output logic       zeroext,
    output logic [1:0] regdst,
    output logic [1:0] memtoreg,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [3:0] alucontrol,
    output logic       illegal,
    output logic       err
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB,
        BEQEX, BNEEX, IEX, IWB, JEX, JALEX, ERROR
    } state_t;

    typedef struct packed {
        logic       pcen;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       alusrca;
        logic       iord;
        logic       zeroext;
        logic [1:0] regdst;
        logic [1:0] memtoreg;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [3:0] alucontrol;
        logic       illegal;
        logic       err;
    } ctl_t;

    state_t          state_reg, state_next;
    logic [TO_W-1:0] count_reg, count_next;
    logic            run_reg;
    logic            waiting;
    logic            timed_out;
    ctl_t            ctl;

    // run_reg holds outputs quiet until the first clock edge after reset release
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= FETCH;
            count_reg <= '0;
            run_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            run_reg   <= 1'b1;
        end
    end

    assign waiting   = ((state_reg == FETCH) || (state_reg == MEMRD) || (state_reg == MEMWR))
                       && !mem_ready;
    assign timed_out = (TIMEOUT > 0) && waiting && (count_reg == TO_LAST);

    always_comb begin
        ctl        = '0;
        state_next = state_reg;
        case (state_reg)
            FETCH: begin
                ctl.memread    = 1'b1;
                ctl.alusrcb    = 2'b01;
                ctl.alucontrol = ALU_ADD;
                if (mem_ready) begin
                    ctl.irwrite = 1'b1;
                    ctl.pcen    = 1'b1;
                    state_next  = DECODE;
                end else if (timed_out) begin
                    state_next = ERROR;
                end
            end
            DECODE: begin
                ctl.alusrcb    = 2'b11;
                ctl.alucontrol = ALU_ADD;
                case (op)
                    OP_LW, OP_SW:                     state_next = MEMADR;
                    OP_RTYPE:                         state_next = RTYPEEX;
                    OP_BEQ:                           state_next = BEQEX;
                    OP_BNE:                           state_next = BNEEX;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_next = IEX;
                    OP_J:                             state_next = JEX;
                    OP_JAL:                           state_next = JALEX;
                    default: begin
                        ctl.illegal = 1'b1;
                        state_next  = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                ctl.alusrca    = 1'b1;
                ctl.alusrcb    = 2'b10;
                ctl.alucontrol = ALU_ADD;
                if (op == OP_SW)
                    state_next = MEMWR;
                else if (op == OP_LW)
                    state_next = MEMRD;
                else
                    state_next = FETCH;
            end
            MEMRD: begin
                ctl.iord    = 1'b1;
                ctl.memread = 1'b1;
                if (mem_ready)
                    state_next = MEMWB;
                else if (timed_out)
                    state_next = ERROR;
            end
            MEMWB: begin
                ctl.regwrite = 1'b1;
                ctl.memtoreg = 2'b01;
                state_next   = FETCH;
            end
            MEMWR: begin
                ctl.iord     = 1'b1;
                ctl.memwrite = 1'b1;
                if (mem_ready)
                    state_next = FETCH;
                else if (timed_out)
                    state_next = ERROR;
            end
            RTYPEEX: begin
                ctl.alusrca = 1'b1;
                state_next  = RTYPEWB;
                case (funct)
                    6'b100000: ctl.alucontrol = ALU_ADD;
                    6'b100010: ctl.alucontrol = ALU_SUB;
                    6'b100100: ctl.alucontrol = ALU_AND;
                    6'b100101: ctl.alucontrol = ALU_OR;
                    6'b101010: ctl.alucontrol = ALU_SLT;
                    6'b100111: ctl.alucontrol = ALU_NOR;
                    default: begin
                        ctl.illegal = 1'b1;
                        state_next  = FETCH;
                    end
                endcase
            end
            RTYPEWB: begin
                ctl.regwrite = 1'b1;
                ctl.regdst   = 2'b01;
                state_next   = FETCH;
            end
            BEQEX, BNEEX: begin
                ctl.alusrca    = 1'b1;
                ctl.alucontrol = ALU_SUB;
                ctl.pcsrc      = 2'b01;
                ctl.pcen       = (state_reg == BEQEX) ? zero : ~zero;
                state_next     = FETCH;
            end
            IEX: begin
                ctl.alusrca = 1'b1;
                ctl.alusrcb = 2'b10;
                case (op)
                    OP_ANDI: begin
                        ctl.alucontrol = ALU_AND;
                        ctl.zeroext    = 1'b1;
                    end
                    OP_ORI: begin
                        ctl.alucontrol = ALU_OR;
                        ctl.zeroext    = 1'b1;
                    end
                    OP_SLTI: ctl.alucontrol = ALU_SLT;
                    default: ctl.alucontrol = ALU_ADD;
                endcase
                state_next = IWB;
            end
            IWB: begin
                ctl.regwrite = 1'b1;
                state_next   = FETCH;
            end
            JEX, JALEX: begin
                ctl.pcen  = 1'b1;
                ctl.pcsrc = 2'b10;
                if (state_reg == JALEX) begin
                    ctl.regwrite = 1'b1;
                    ctl.regdst   = 2'b10;
                    ctl.memtoreg = 2'b10;
                end
                state_next = FETCH;
            end
            ERROR: begin
                ctl.err    = 1'b1;
                state_next = ERROR;
            end
            default: state_next = FETCH;
        endcase

        if (!run_reg) begin
            ctl        = '0;
            state_next = FETCH;
        end
    end

    // Counter clears on entry to a wait state and on mem_ready; saturates at all-ones
    always_comb begin
        count_next = '0;
        if (run_reg && waiting && (state_next == state_reg))
            count_next = (count_reg == '1) ? count_reg : count_reg + TO_W'(1);
    end

    assign pcen       = ctl.pcen;
    assign memread    = ctl.memread;
    assign memwrite   = ctl.memwrite;
    assign irwrite    = ctl.irwrite;
    assign regwrite   = ctl.regwrite;
    assign alusrca    = ctl.alusrca;
    assign iord       = ctl.iord;
    assign zeroext    = ctl.zeroext;
    assign regdst     = ctl.regdst;
    assign memtoreg   = ctl.memtoreg;
    assign alusrcb    = ctl.alusrcb;
    assign pcsrc      = ctl.pcsrc;
    assign alucontrol = ctl.alucontrol;
    assign illegal    = ctl.illegal;
    assign err        = ctl.err;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl: walks each instruction class cycle by cycle
// and compares the full control word against hand-written expected words.
module tb_mips_mc_ctrl;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pcen, memread, memwrite, irwrite, regwrite, alusrca, iord, zeroext;
    logic [1:0] regdst, memtoreg, alusrcb, pcsrc;
    logic [3:0] alucontrol;
    logic       illegal, err;
    logic [23:0] obs;

    int n_vec = 0;
    int n_err = 0;

    mips_mc_ctrl #(.TIMEOUT(16), .TO_W(5)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pcen(pcen), .memread(memread), .memwrite(memwrite),
        .irwrite(irwrite), .regwrite(regwrite), .alusrca(alusrca), .iord(iord),
        .zeroext(zeroext), .regdst(regdst), .memtoreg(memtoreg), .alusrcb(alusrcb),
        .pcsrc(pcsrc), .alucontrol(alucontrol), .illegal(illegal), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs = {pcen, memread, memwrite, irwrite, regwrite, alusrca, iord, zeroext,
                  regdst, memtoreg, alusrcb, pcsrc, alucontrol, illegal, err};

    localparam logic L = 1'b0;
    localparam logic H = 1'b1;

    function automatic logic [23:0] cv(
        input logic pe, mr, mw, ir, rw, sa, io, zx,
        input logic [1:0] rd, mt, sb, ps,
        input logic [3:0] alu,
        input logic il, er);
        return {pe, mr, mw, ir, rw, sa, io, zx, rd, mt, sb, ps, alu, il, er};
    endfunction

    localparam logic [23:0] E_ZERO       = 24'h0;
    localparam logic [23:0] E_FETCH_W    = cv(L,H,L,L,L,L,L,L,2'b00,2'b00,2'b01,2'b00,4'b0010,L,L);
    localparam logic [23:0] E_FETCH_R    = cv(H,H,L,H,L,L,L,L,2'b00,2'b00,2'b01,2'b00,4'b0010,L,L);
    localparam logic [23:0] E_DECODE     = cv(L,L,L,L,L,L,L,L,2'b00,2'b00,2'b11,2'b00,4'b0010,L,L);
    localparam logic [23:0] E_DECODE_ILL = cv(L,L,L,L,L,L,L,L,2'b00,2'b00,2'b11,2'b00,4'b0010,H,L);
    localparam logic [23:0] E_MEMADR     = cv(L,L,L,L,L,H,L,L,2'b00,2'b00,2'b10,2'b00,4'b0010,L,L);
    localparam logic [23:0] E_MEMRD      = cv(L,H,L,L,L,L,H,L,2'b00,2'b00,2'b00,2'b00,4'b0000,L,L);
    localparam logic [23:0] E_MEMWB      = cv(L,L,L,L,H,L,L,L,2'b00,2'b01,2'b00,2'b00,4'b0000,L,L);
    localparam logic [23:0] E_MEMWR      = cv(L,L,H,L,L,L,H,L,2'b00,2'b00,2'b00,2'b00,4'b0000,L,L);
    localparam logic [23:0] E_RTYPE_ILL  = cv(L,L,L,L,L,H,L,L,2'b00,2'b00,2'b00,2'b00,4'b0000,H,L);
    localparam logic [23:0] E_RTYPEWB    = cv(L,L,L,L,H,L,L,L,2'b01,2'b00,2'b00,2'b00,4'b0000,L,L);
    localparam logic [23:0] E_IWB        = cv(L,L,L,L,H,L,L,L,2'b00,2'b00,2'b00,2'b00,4'b0000,L,L);
    localparam logic [23:0] E_JEX        = cv(H,L,L,L,L,L,L,L,2'b00,2'b00,2'b00,2'b10,4'b0000,L,L);
    localparam logic [23:0] E_JALEX      = cv(H,L,L,L,H,L,L,L,2'b10,2'b10,2'b00,2'b10,4'b0000,L,L);
    localparam logic [23:0] E_ERROR      = cv(L,L,L,L,L,L,L,L,2'b00,2'b00,2'b00,2'b00,4'b0000,L,H);

    function automatic logic [23:0] e_rtype(input logic [3:0] alu);
        return cv(L,L,L,L,L,H,L,L,2'b00,2'b00,2'b00,2'b00,alu,L,L);
    endfunction

    function automatic logic [23:0] e_branch(input logic pe);
        return cv(pe,L,L,L,L,H,L,L,2'b00,2'b00,2'b00,2'b01,4'b0110,L,L);
    endfunction

    function automatic logic [23:0] e_iex(input logic [3:0] alu, input logic zx);
        return cv(L,L,L,L,L,H,L,zx,2'b00,2'b00,2'b10,2'b00,alu,L,L);
    endfunction

    task automatic check_vec(input string tag, input logic [23:0] got, input logic [23:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Inputs are set right after a falling edge; outputs are sampled 1ns later.
    task automatic cyc(input string tag, input logic [23:0] exp);
        #1;
        check_vec(tag, obs, exp);
        @(negedge clk);
    endtask

    task automatic fetch_decode(input string tag, input logic [5:0] o, input logic [5:0] f);
        op        = o;
        funct     = f;
        mem_ready = 1'b1;
        cyc({tag, "_fetch"}, E_FETCH_R);
        mem_ready = 1'b0;
        cyc({tag, "_decode"}, E_DECODE);
    endtask

    logic [5:0] r_funct [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
    logic [3:0] r_alu   [6] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b1100};
    logic [5:0] i_op    [4] = '{6'b001000, 6'b001100, 6'b001101, 6'b001010};
    logic [3:0] i_alu   [4] = '{4'b0010, 4'b0000, 4'b0001, 4'b0111};
    logic       i_zx    [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [5:0] b_op    [4] = '{6'b000100, 6'b000100, 6'b000101, 6'b000101};
    logic       b_zero  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic       b_pcen  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        reset     = 1'b0;
        op        = 6'b0;
        funct     = 6'b0;
        zero      = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        mem_ready = 1'b1;
        cyc("reset_hold", E_ZERO);
        reset     = 1'b1;
        mem_ready = 1'b0;
        cyc("pre_first_edge", E_ZERO);

        // watchdog: 16 FETCH cycles without mem_ready, then ERROR
        for (int i = 0; i < 16; i++)
            cyc($sformatf("to_fetch_wait%0d", i), E_FETCH_W);
        cyc("to_error", E_ERROR);
        mem_ready = 1'b1;
        cyc("error_absorb", E_ERROR);
        reset = 1'b0;
        cyc("reset_clears_err", E_ZERO);
        reset     = 1'b1;
        mem_ready = 1'b0;
        cyc("pre_first_edge2", E_ZERO);

        // lw with two wait cycles in MEMRD
        op = 6'b100011;
        cyc("lw_fetch_wait", E_FETCH_W);
        fetch_decode("lw", 6'b100011, 6'b0);
        cyc("lw_memadr", E_MEMADR);
        cyc("lw_memrd0", E_MEMRD);
        cyc("lw_memrd1", E_MEMRD);
        mem_ready = 1'b1;
        cyc("lw_memrd2", E_MEMRD);
        mem_ready = 1'b0;
        cyc("lw_memwb", E_MEMWB);

        fetch_decode("sw", 6'b101011, 6'b0);
        cyc("sw_memadr", E_MEMADR);
        mem_ready = 1'b1;
        cyc("sw_memwr", E_MEMWR);
        mem_ready = 1'b0;

        for (int i = 0; i < 6; i++) begin
            fetch_decode($sformatf("r%0d", i), 6'b000000, r_funct[i]);
            cyc($sformatf("r%0d_ex", i), e_rtype(r_alu[i]));
            cyc($sformatf("r%0d_wb", i), E_RTYPEWB);
        end

        fetch_decode("rbad", 6'b000000, 6'b000001);
        cyc("rbad_ex", E_RTYPE_ILL);
        cyc("rbad_back_fetch", E_FETCH_W);

        // mem_ready is driven high during EX to show it is ignored there
        for (int i = 0; i < 4; i++) begin
            fetch_decode($sformatf("br%0d", i), b_op[i], 6'b0);
            zero      = b_zero[i];
            mem_ready = 1'b1;
            cyc($sformatf("br%0d_ex", i), e_branch(b_pcen[i]));
            zero      = 1'b0;
            mem_ready = 1'b0;
        end

        for (int i = 0; i < 4; i++) begin
            fetch_decode($sformatf("imm%0d", i), i_op[i], 6'b0);
            cyc($sformatf("imm%0d_ex", i), e_iex(i_alu[i], i_zx[i]));
            cyc($sformatf("imm%0d_wb", i), E_IWB);
        end

        fetch_decode("j", 6'b000010, 6'b0);
        cyc("j_ex", E_JEX);
        fetch_decode("jal", 6'b000011, 6'b0);
        cyc("jal_ex", E_JALEX);

        op        = 6'b111111;
        mem_ready = 1'b1;
        cyc("bad_op_fetch", E_FETCH_R);
        mem_ready = 1'b0;
        cyc("bad_op_decode", E_DECODE_ILL);
        cyc("bad_op_back_fetch", E_FETCH_W);

        // reset pulled low in the middle of a MEMWR wait
        fetch_decode("swr", 6'b101011, 6'b0);
        cyc("swr_memadr", E_MEMADR);
        #1;
        check_vec("swr_memwr", obs, E_MEMWR);
        #2 reset = 1'b0;
        #1;
        check_vec("reset_mid_memwr", obs, E_ZERO);
        @(negedge clk);
        cyc("reset_held", E_ZERO);
        reset = 1'b1;
        cyc("pre_first_edge3", E_ZERO);
        cyc("post_reset_fetch", E_FETCH_W);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mips_mc_ctrl.md
MIPS_MC_CTRL -- requirements
Module: mips_mc_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning memory-wait cycles before error; 0 disables the watchdog.
REQ-002 SHALL have parameter TO_W, default 5, meaning wait-counter width; TO_W SHALL be at least clog2(TIMEOUT+1).
REQ-003 SHALL have clock and reset as decided: one clock; reset is asynchronous and active-low.
REQ-004 SHALL have ports, one per line, as follows:
- clk  in  1  clock
- reset  in  1  async active-low reset
- op  in  6  instr[31:26]
- funct  in  6  instr[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- pcen  out  1  PC write enable
- memread  out  1  memory read request
- memwrite  out  1  memory write request
- irwrite  out  1  IR load
- regwrite  out  1  register-file write
- alusrca  out  1  0 = PC, 1 = A
- iord  out  1  0 = PC address, 1 = ALUOut address
- zeroext  out  1  immediate is zero-extended
- regdst  out  2  00 = rt, 01 = rd, 10 = $31
- memtoreg  out  2  00 = ALUOut, 01 = Data, 10 = PC
- alusrcb  out  2  00 = B, 01 = 4, 10 = imm, 11 = imm<<2
- pcsrc  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target
- alucontrol  out  4  0010 = add, 0110 = sub, 0000 = and, 0001 = or, 0111 = slt, 1100 = nor
- illegal  out  1  one-cycle pulse on an undecodable instruction
- err  out  1  sticky memory-timeout flag

Function
REQ-005 SHALL implement the states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, BNEEX, IEX, IWB, JEX, JALEX and ERROR.
REQ-006 SHALL decode the opcodes lw 100011, sw 101011, R-type 000000, beq 000100, bne 000101, addi 001000, andi 001100, ori 001101, slti 001010, j 000010 and jal 000011.
REQ-007 SHALL drive outputs as a function of state, plus mem_ready where stated; every output not listed for a state SHALL be 0.
REQ-008 FETCH SHALL assert memread=1 and alusrcb=01 (add), and SHALL assert irwrite=1 and pcen=1 only in the cycle mem_ready=1; it SHALL then go to DECODE, and otherwise stay in FETCH.
REQ-009 DECODE SHALL drive alusrcb=11 (add), then go to MEMADR for lw/sw, RTYPEEX, BEQEX, BNEEX or IEX for addi/andi/ori/slti, JEX or JALEX.
REQ-010 On any other opcode, DECODE SHALL pulse illegal=1 and return to FETCH.
REQ-011 MEMADR SHALL drive alusrca=1 and alusrcb=10 (add), then go to MEMRD for lw or MEMWR for sw.
REQ-012 MEMRD SHALL drive iord=1 and memread=1, and SHALL hold until mem_ready=1, then go to MEMWB.
REQ-013 MEMWB SHALL drive regwrite=1 and memtoreg=01, then go to FETCH.
REQ-014 MEMWR SHALL drive iord=1 and memwrite=1, and SHALL hold until mem_ready=1, then go to FETCH.
REQ-015 RTYPEEX SHALL drive alusrca=1 and alucontrol decoded from funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, 100111 nor.
REQ-016 On any other funct, RTYPEEX SHALL pulse illegal=1 and go to FETCH; otherwise it SHALL go to RTYPEWB.
REQ-017 RTYPEWB SHALL drive regwrite=1 and regdst=01, then go to FETCH.
REQ-018 BEQEX and BNEEX SHALL drive alusrca=1, sub and pcsrc=01, then go to FETCH.
REQ-019 In BEQEX, pcen SHALL equal zero; in BNEEX, pcen SHALL equal ~zero.
REQ-020 IEX SHALL drive alusrca=1 and alusrcb=10, with add for addi, and for andi, or for ori, and slt for slti.
REQ-021 IEX SHALL drive zeroext=1 for andi/ori only, then go to IWB.
REQ-022 IWB SHALL drive regwrite=1 and regdst=00, then go to FETCH.
REQ-023 JEX SHALL drive pcsrc=10 and pcen=1, then go to FETCH.
REQ-024 JALEX SHALL do the same as JEX and additionally drive regwrite=1, regdst=10 and memtoreg=10 (PC already holds PC+4).
REQ-025 A wait counter SHALL clear on entry to FETCH, MEMRD or MEMWR and on mem_ready=1, and SHALL increment each waiting cycle.
REQ-026 When TIMEOUT>0 and the counter reaches TIMEOUT-1 with mem_ready=0, the block SHALL go to ERROR.
REQ-027 ERROR SHALL be absorbing until reset, SHALL hold err=1, and SHALL hold all enables and requests at 0.
REQ-028 mem_ready SHALL be ignored in every state except FETCH, MEMRD and MEMWR.
REQ-029 The counter SHALL saturate and SHALL never wrap.

Reset
REQ-030 While reset=0, the state SHALL be FETCH, the counter 0, err 0, and every output 0, regardless of the clock.
REQ-031 On the first rising clk after reset deasserts, FETCH outputs SHALL apply.
REQ-032 Reset asserted mid-instruction SHALL abort the instruction immediately, with no write enable asserted afterwards.

Verification
REQ-033 lw with mem_ready low for 2 cycles in MEMRD -> sequence FETCH, DECODE, MEMADR, MEMRD x3, MEMWB; exactly one regwrite with memtoreg=01.
REQ-034 bne with zero=0 -> pcen=1 in BNEEX; bne with zero=1 -> pcen=0; beq shows the inverse.
REQ-035 jal -> JALEX single cycle with pcen=1, regwrite=1, regdst=10, memtoreg=10, pcsrc=10.
REQ-036 ori -> IEX with alucontrol=0001 and zeroext=1, then IWB with regdst=00 and regwrite=1.
REQ-037 op=111111 -> illegal high for exactly 1 cycle in DECODE, then FETCH; R-type funct 000001 behaves the same in RTYPEEX.
REQ-038 TIMEOUT=16, mem_ready held 0 in FETCH -> ERROR entered after 16 cycles with err=1; reset=0 clears err; reset pulled low during MEMWR -> memwrite drops immediately.
